can_rx_frame_seq: RTL
=====================

# can_rx_frame_seq

Receive-side field sequencer for CAN 2.0A (standard, 11-bit ID) frames. It sits between the bit-timing/sampling logic and the CRC engine. It walks each frame bit by bit from SOF to the CRC delimiter and drives the CRC engine's clear and enable over exactly the CRC-covered bits (SOF through the last DATA bit). It extracts ID, RTR and DLC, collects the received 15-bit CRC sequence, compares it with the engine result, and reports per-frame status.

## Interface
Parameters:
- MAX_DATA_BYTES, default 8: DLC values above this are clamped to this byte count (CAN 2.0 rule).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- bit_stb  in  1  one-cycle pulse at each sample point. Minimum spacing is 3 clk cycles.
- rx_bit  in  1  sampled bus bit; 0 = dominant. Valid only while bit_stb is high.
- rx_abort  in  1  upstream error or bus-off. Forces IDLE.
- crc_clr_n  out  1  active-low clear for the CRC engine. Held low in IDLE.
- crc_en  out  1  one-cycle pulse per CRC-covered bit.
- crc_din  out  1  bit fed to the CRC engine. Valid with crc_en.
- crc_in  in  15  CRC engine result.
- id  out  11  received identifier, MSB first.
- rtr  out  1  received RTR bit.
- dlc  out  4  received DLC, unclamped.
- frame_done  out  1  one-cycle pulse when a frame completes at a valid CRC delimiter.
- crc_ok  out  1  one-cycle pulse with frame_done if the received CRC equals the computed CRC.
- crc_err  out  1  one-cycle pulse with frame_done on a CRC mismatch.
- form_err  out  1  one-cycle pulse on an IDE or delimiter form violation. The frame is aborted.
- stuff_err  out  1  one-cycle pulse on a stuff violation. Active only with the stuff filter compiled in.

## Operation
States and transitions:
- IDLE: crc_clr_n=0. On bit_stb with rx_bit=0 (SOF), go to ARB and feed SOF (0) to the CRC engine.
- ARB: 12 bits, ID[10:0] then RTR. Shift into id and rtr.
- CTRL: 6 bits, IDE, r0, DLC[3:0].
  - IDE=1 → pulse form_err, go to IDLE.
  - r0 is not checked.
- DATA: 8·min(dlc, MAX_DATA_BYTES) bits. Skipped entirely when rtr=1 or dlc=0.
- CRC: 15 bits, shifted MSB first into rx_crc.
- CDEL: 1 bit.
  - rx_bit=1 → pulse frame_done plus crc_ok or crc_err, go to IDLE.
  - rx_bit=0 → pulse form_err, go to IDLE.

Counting and CRC handling:
- A 7-bit bit counter is reloaded on each state entry and counts down one per consumed bit.
- crc_en/crc_din are issued for every consumed bit in SOF, ARB, CTRL and DATA, and for no other bit.
- crc_in is captured into a snapshot register in the cycle after the final crc_en pulse. The comparison uses the snapshot against rx_crc.
- Field outputs (id, rtr, dlc) hold their last values until the next SOF.

Boundary conditions:
- rx_abort has priority over bit_stb in the same cycle. The state goes to IDLE and no status pulse is issued.
- rst_n asserted mid-frame: go to IDLE immediately. All outputs return to their reset values.
- dlc 9..15 with MAX_DATA_BYTES=8: 64 data bits.

## Timing
- All outputs are registered.
- Reset values:
  - crc_clr_n=0.
  - crc_en, crc_din, id, rtr, dlc, and every status pulse = 0.
- Bit strobed in cycle N:
  - its crc_en pulse appears in cycle N+1;
  - the resulting state change is visible in N+1.
- At SOF in cycle N, crc_clr_n goes high in N+1, together with the SOF crc_en pulse.
- Status pulses (frame_done, crc_ok, crc_err, form_err, stuff_err) appear in cycle N+1 after the deciding bit.
- Exactly one of crc_ok or crc_err fires with each frame_done.
- After an abort or error, crc_clr_n=0 from N+1.

## Configuration
- STUFF_FILTER_EN defined:
  - Bit destuffing runs from SOF through the last CRC bit. A run counter tracks consecutive equal consumed bits.
  - After 5 equal bits, the next strobed bit is a stuff bit.
  - If the stuff bit differs from the run, it is discarded: not counted and not fed to the CRC engine. The run restarts at 1 with its value.
  - If the stuff bit equals the run, pulse stuff_err and go to IDLE.
  - The CRC delimiter bit is not subject to stuffing.
- STUFF_FILTER_EN undefined:
  - Every bit_stb is a frame bit; the input is already destuffed.
  - stuff_err is tied to 0.

## Test plan
- ID=0x123, RTR=0, DLC=1, data 0x55, correct CRC → 27 crc_en pulses; id=0x123, dlc=1; frame_done and crc_ok together; crc_err=0.
- Same frame with CRC bit 7 inverted → frame_done with crc_err=1 and crc_ok=0.
- RTR=1, DLC=4 → 19 crc_en pulses; DATA skipped; frame_done 16 bits after the last DLC bit.
- DLC=15 → 83 crc_en pulses (64 data bits); valid CRC → crc_ok.
- IDE=1 → form_err one cycle after the IDE strobe, no frame_done. Dominant CRC delimiter → form_err, no frame_done.
- rx_abort mid-DATA → crc_clr_n=0 next cycle, no status pulses.
- With STUFF_FILTER_EN, ID=0x000 frame with stuff bits inserted → id=0x000, crc_ok. Six consecutive dominant bits → stuff_err.

Source files
------------

// File: rtl/can_rx_frame_seq.sv
// can_rx_frame_seq
// Receive-side field sequencer for CAN 2.0A (11-bit ID) frames. It walks a
// frame bit by bit from SOF to the CRC delimiter and drives the external CRC
// engine's clear/enable over SOF..last DATA bit. It also extracts ID/RTR/DLC,
// collects the received CRC, compares it with a snapshot of the engine result,
// and reports per-frame status.
//
// Optional build macro: STUFF_FILTER_EN
//   When defined, bit destuffing runs from SOF through the last CRC bit, and
//   stuff violations are reported on stuff_err. When undefined, every bit_stb
//   is a frame bit and stuff_err stays 0.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   bit_stb        one-cycle pulse per sample point (>= 3 clk apart)
//   rx_bit         sampled bus bit (0 = dominant), valid with bit_stb
//   rx_abort       upstream error / bus-off, forces IDLE (beats bit_stb)
//   crc_clr_n      CRC engine clear, low while idle
//   crc_en/crc_din CRC engine feed, one pulse per CRC-covered bit
//   crc_in         CRC engine result
//   id, rtr, dlc   received fields (dlc unclamped), held until next SOF
//   frame_done     pulse at a valid recessive CRC delimiter
//   crc_ok/crc_err exactly one of them with frame_done
//   form_err       pulse on IDE=1 or a dominant CRC delimiter
//   stuff_err      pulse on a stuff violation (stuff filter builds only)
module can_rx_frame_seq #(
  parameter int MAX_DATA_BYTES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bit_stb,
  input  logic        rx_bit,
  input  logic        rx_abort,
  output logic        crc_clr_n,
  output logic        crc_en,
  output logic        crc_din,
  input  logic [14:0] crc_in,
  output logic [10:0] id,
  output logic        rtr,
  output logic [3:0]  dlc,
  output logic        frame_done,
  output logic        crc_ok,
  output logic        crc_err,
  output logic        form_err,
  output logic        stuff_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_CTRL, S_DATA, S_CRC, S_CDEL
  } state_t;

  state_t      state_reg, state_next;
  logic [6:0]  cnt_reg, cnt_next;      // bits left in the field, minus one
  logic [10:0] id_next;
  logic        rtr_next;
  logic [3:0]  dlc_next;
  logic [14:0] rx_crc_reg, rx_crc_next;
  logic [14:0] crc_snap_reg;
  logic        last_en_reg, last_next; // marks the final crc_en pulse
  logic        snap_pend_reg;          // engine result settles one cycle later
  logic        en_next, din_next;
  logic        done_next, ok_next, err_next, form_next, stuff_next;
  logic        consume;
  int          nbytes;

`ifdef STUFF_FILTER_EN
  logic        run_val_reg, run_val_next;
  logic [2:0]  run_cnt_reg, run_cnt_next;
`endif

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    id_next     = id;
    rtr_next    = rtr;
    dlc_next    = dlc;
    rx_crc_next = rx_crc_reg;
    last_next   = 1'b0;
    en_next     = 1'b0;
    din_next    = 1'b0;
    done_next   = 1'b0;
    ok_next     = 1'b0;
    err_next    = 1'b0;
    form_next   = 1'b0;
    stuff_next  = 1'b0;
    consume     = 1'b1;
    nbytes      = 0;
`ifdef STUFF_FILTER_EN
    run_val_next = run_val_reg;
    run_cnt_next = run_cnt_reg;
`endif

    if (rx_abort) begin
      state_next = S_IDLE;
    end else if (bit_stb) begin
`ifdef STUFF_FILTER_EN
      // The delimiter (S_CDEL) and idle bits are outside the stuffed region.
      if (state_reg inside {S_ARB, S_CTRL, S_DATA, S_CRC}) begin
        if (run_cnt_reg == 3'd5) begin
          consume = 1'b0;
          if (rx_bit == run_val_reg) begin
            stuff_next = 1'b1;
            state_next = S_IDLE;
          end else begin
            run_val_next = rx_bit;
            run_cnt_next = 3'd1;
          end
        end else if (rx_bit == run_val_reg) begin
          run_cnt_next = run_cnt_reg + 3'd1;
        end else begin
          run_val_next = rx_bit;
          run_cnt_next = 3'd1;
        end
      end
`endif
      if (consume) begin
        case (state_reg)
          S_IDLE: begin
            if (!rx_bit) begin
              state_next = S_ARB;
              cnt_next   = 7'd11;
              id_next    = '0;
              rtr_next   = 1'b0;
              dlc_next   = '0;
              en_next    = 1'b1;
              din_next   = 1'b0;
`ifdef STUFF_FILTER_EN
              run_val_next = 1'b0;
              run_cnt_next = 3'd1;
`endif
            end
          end
          S_ARB: begin
            en_next  = 1'b1;
            din_next = rx_bit;
            if (cnt_reg == 7'd0) begin
              rtr_next   = rx_bit;
              state_next = S_CTRL;
              cnt_next   = 7'd5;
            end else begin
              id_next  = {id[9:0], rx_bit};
              cnt_next = cnt_reg - 7'd1;
            end
          end
          S_CTRL: begin
            en_next  = 1'b1;
            din_next = rx_bit;
            // IDE and r0 shift through and fall out; the last four are DLC.
            dlc_next = {dlc[2:0], rx_bit};
            if (cnt_reg == 7'd5 && rx_bit) begin
              form_next  = 1'b1;
              state_next = S_IDLE;
            end else if (cnt_reg == 7'd0) begin
              nbytes = (int'(dlc_next) > MAX_DATA_BYTES) ? MAX_DATA_BYTES
                                                         : int'(dlc_next);
              if (rtr || nbytes == 0) begin
                state_next = S_CRC;
                cnt_next   = 7'd14;
                last_next  = 1'b1;
              end else begin
                state_next = S_DATA;
                cnt_next   = 7'(nbytes * 8 - 1);
              end
            end else begin
              cnt_next = cnt_reg - 7'd1;
            end
          end
          S_DATA: begin
            en_next  = 1'b1;
            din_next = rx_bit;
            if (cnt_reg == 7'd0) begin
              state_next = S_CRC;
              cnt_next   = 7'd14;
              last_next  = 1'b1;
            end else begin
              cnt_next = cnt_reg - 7'd1;
            end
          end
          S_CRC: begin
            rx_crc_next = {rx_crc_reg[13:0], rx_bit};
            if (cnt_reg == 7'd0) begin
              state_next = S_CDEL;
            end else begin
              cnt_next = cnt_reg - 7'd1;
            end
          end
          S_CDEL: begin
            state_next = S_IDLE;
            if (rx_bit) begin
              done_next = 1'b1;
              ok_next   = (rx_crc_reg == crc_snap_reg);
              err_next  = (rx_crc_reg != crc_snap_reg);
            end else begin
              form_next = 1'b1;
            end
          end
          default: state_next = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      rx_crc_reg    <= '0;
      crc_snap_reg  <= '0;
      last_en_reg   <= 1'b0;
      snap_pend_reg <= 1'b0;
      crc_clr_n     <= 1'b0;
      crc_en        <= 1'b0;
      crc_din       <= 1'b0;
      id            <= '0;
      rtr           <= 1'b0;
      dlc           <= '0;
      frame_done    <= 1'b0;
      crc_ok        <= 1'b0;
      crc_err       <= 1'b0;
      form_err      <= 1'b0;
      stuff_err     <= 1'b0;
`ifdef STUFF_FILTER_EN
      run_val_reg   <= 1'b0;
      run_cnt_reg   <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      rx_crc_reg    <= rx_crc_next;
      last_en_reg   <= last_next;
      snap_pend_reg <= last_en_reg;
      if (snap_pend_reg) begin
        crc_snap_reg <= crc_in;
      end
      crc_clr_n     <= (state_next != S_IDLE);
      crc_en        <= en_next;
      crc_din       <= din_next;
      id            <= id_next;
      rtr           <= rtr_next;
      dlc           <= dlc_next;
      frame_done    <= done_next;
      crc_ok        <= ok_next;
      crc_err       <= err_next;
      form_err      <= form_next;
      stuff_err     <= stuff_next;
`ifdef STUFF_FILTER_EN
      run_val_reg   <= run_val_next;
      run_cnt_reg   <= run_cnt_next;
`endif
    end
  end

endmodule
